instr_register_alu: RTL and testbench

Parametrised successor to the instruction register: a DEPTH-entry instruction store that accepts opcode/operand writes, computes each instruction's result in a two-stage write pipeline, and returns opcode, operands, result and status on a registered read port. It sits between the instruction-issue stimulus and the result checker. Compared with the fixed 32 × 32-bit register, it adds configurable width and depth, per-entry valid tracking, divide-by-zero flagging, an occupancy counter and optional auto-increment write addressing.

---
 rtl/instr_register_alu.sv | 213 +++++++++++++++++++++
 tb/tb_instr_register_alu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_register_alu.sv
// DEPTH-entry instruction store: two-stage write pipeline computing signed results, write-first registered read.
// Optional INSTR_REG_AUTO_INC_EN: write address from an internal wrapping pointer instead of write_pointer.
module instr_register_alu #(
    parameter int OP_WIDTH   = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic [2:0]                   opcode,
    input  logic signed [OP_WIDTH-1:0]   operand_a,
    input  logic signed [OP_WIDTH-1:0]   operand_b,
    input  logic [ADDR_WIDTH-1:0]        write_pointer,
    input  logic                         read_en,
    input  logic [ADDR_WIDTH-1:0]        read_pointer,
    output logic                         rd_valid,
    output logic                         rd_hit,
    output logic [2:0]                   rd_opcode,
    output logic signed [OP_WIDTH-1:0]   rd_op_a,
    output logic signed [OP_WIDTH-1:0]   rd_op_b,
    output logic signed [2*OP_WIDTH-1:0] rd_res,
    output logic                         rd_dz,
    output logic [ADDR_WIDTH:0]          valid_count
);

    localparam int RW = 2 * OP_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    logic [ADDR_WIDTH-1:0] wr_addr;

`ifdef INSTR_REG_AUTO_INC_EN
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  unused_write_pointer;

    assign unused_write_pointer = ^write_pointer;
    assign wr_ptr_d = (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    assign wr_addr  = wr_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
        end else if (load_en) begin
            wr_ptr_q <= wr_ptr_d;
        end
    end
`else
    assign wr_addr = write_pointer;
`endif

    // ---------------- Stage S1 ----------------
    logic                       s1_valid_q;
    logic [2:0]                 s1_opcode_q;
    logic signed [OP_WIDTH-1:0] s1_a_q, s1_b_q;
    logic [ADDR_WIDTH-1:0]      s1_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= load_en;
        end
        if (load_en) begin
            s1_opcode_q <= opcode;
            s1_a_q      <= operand_a;
            s1_b_q      <= operand_b;
            s1_addr_q   <= wr_addr;
        end
    end

    // ---------------- Stage S2 arithmetic ----------------
    logic signed [RW-1:0] a_ext, b_ext, div_b;
    logic signed [RW-1:0] res_d;
    logic                 dz_d;
    logic                 b_zero;

    assign a_ext  = {{OP_WIDTH{s1_a_q[OP_WIDTH-1]}}, s1_a_q};
    assign b_ext  = {{OP_WIDTH{s1_b_q[OP_WIDTH-1]}}, s1_b_q};
    assign b_zero = (s1_b_q == '0);
    // Divisor is forced to 1 on b=0 so the divider never sees zero; result is masked anyway.
    assign div_b  = b_zero ? RW'(1) : b_ext;

    always_comb begin
        res_d = '0;
        dz_d  = 1'b0;
        case (s1_opcode_q)
            OP_ZERO:  res_d = '0;
            OP_PASSA: res_d = a_ext;
            OP_PASSB: res_d = b_ext;
            OP_ADD:   res_d = a_ext + b_ext;
            OP_SUB:   res_d = a_ext - b_ext;
            OP_MULT:  res_d = a_ext * b_ext;
            OP_DIV: begin
                if (b_zero) dz_d = 1'b1;
                else        res_d = a_ext / div_b;
            end
            OP_MOD: begin
                if (b_zero) dz_d = 1'b1;
                else        res_d = a_ext % div_b;
            end
            default:  res_d = '0;
        endcase
    end

    // ---------------- Storage ----------------
    logic [2:0]                 mem_opcode [DEPTH];
    logic signed [OP_WIDTH-1:0] mem_a      [DEPTH];
    logic signed [OP_WIDTH-1:0] mem_b      [DEPTH];
    logic signed [RW-1:0]       mem_res    [DEPTH];
    logic                       mem_dz     [DEPTH];
    logic [DEPTH-1:0]           valid_q;
    logic [ADDR_WIDTH:0]        valid_count_q;
    logic                       commit;
    logic                       rd_in_range;

    assign commit      = s1_valid_q && ({1'b0, s1_addr_q} < DEPTH_C);
    assign rd_in_range = ({1'b0, read_pointer} < DEPTH_C);

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_opcode[s1_addr_q] <= s1_opcode_q;
            mem_a[s1_addr_q]      <= s1_a_q;
            mem_b[s1_addr_q]      <= s1_b_q;
            mem_res[s1_addr_q]    <= res_d;
            mem_dz[s1_addr_q]     <= dz_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q[gi] <= 1'b0;
                end else if (commit && (s1_addr_q == ADDR_WIDTH'(gi))) begin
                    valid_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Overwrites of a live entry leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_count_q <= '0;
        end else if (commit && !valid_q[s1_addr_q]) begin
            valid_count_q <= valid_count_q + (ADDR_WIDTH + 1)'(1);
        end
    end

    // ---------------- Read port ----------------
    logic                       rd_valid_q, rd_hit_q, rd_dz_q;
    logic [2:0]                 rd_opcode_q;
    logic signed [OP_WIDTH-1:0] rd_op_a_q, rd_op_b_q;
    logic signed [RW-1:0]       rd_res_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q  <= 1'b0;
            rd_hit_q    <= 1'b0;
            rd_opcode_q <= '0;
            rd_op_a_q   <= '0;
            rd_op_b_q   <= '0;
            rd_res_q    <= '0;
            rd_dz_q     <= 1'b0;
        end else begin
            rd_valid_q <= read_en;
            if (read_en) begin
                if (commit && (s1_addr_q == read_pointer)) begin
                    rd_hit_q    <= 1'b1;
                    rd_opcode_q <= s1_opcode_q;
                    rd_op_a_q   <= s1_a_q;
                    rd_op_b_q   <= s1_b_q;
                    rd_res_q    <= res_d;
                    rd_dz_q     <= dz_d;
                end else if (rd_in_range && valid_q[read_pointer]) begin
                    rd_hit_q    <= 1'b1;
                    rd_opcode_q <= mem_opcode[read_pointer];
                    rd_op_a_q   <= mem_a[read_pointer];
                    rd_op_b_q   <= mem_b[read_pointer];
                    rd_res_q    <= mem_res[read_pointer];
                    rd_dz_q     <= mem_dz[read_pointer];
                end else begin
                    rd_hit_q    <= 1'b0;
                    rd_opcode_q <= '0;
                    rd_op_a_q   <= '0;
                    rd_op_b_q   <= '0;
                    rd_res_q    <= '0;
                    rd_dz_q     <= 1'b0;
                end
            end
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_hit      = rd_hit_q;
    assign rd_opcode   = rd_opcode_q;
    assign rd_op_a     = rd_op_a_q;
    assign rd_op_b     = rd_op_b_q;
    assign rd_res      = rd_res_q;
    assign rd_dz       = rd_dz_q;
    assign valid_count = valid_count_q;

endmodule

// File: tb/tb_instr_register_alu.sv
// Directed table-driven bench for instr_register_alu; auto-increment checks when INSTR_REG_AUTO_INC_EN is defined.
module tb_instr_register_alu;

`ifdef INSTR_REG_AUTO_INC_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 32;
`endif
    localparam int OPW = 32;
    localparam int AW  = $clog2(DEPTH);

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    load_en = 1'b0;
    logic [2:0]              opcode = '0;
    logic signed [OPW-1:0]   operand_a = '0;
    logic signed [OPW-1:0]   operand_b = '0;
    logic [AW-1:0]           write_pointer = '0;
    logic                    read_en = 1'b0;
    logic [AW-1:0]           read_pointer = '0;
    logic                    rd_valid, rd_hit, rd_dz;
    logic [2:0]              rd_opcode;
    logic signed [OPW-1:0]   rd_op_a, rd_op_b;
    logic signed [2*OPW-1:0] rd_res;
    logic [AW:0]             valid_count;

    int tests_run = 0;
    int tests_failed = 0;

    instr_register_alu #(.OP_WIDTH(OPW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .write_pointer(write_pointer),
        .read_en(read_en), .read_pointer(read_pointer),
        .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_opcode(rd_opcode),
        .rd_op_a(rd_op_a), .rd_op_b(rd_op_b), .rd_res(rd_res), .rd_dz(rd_dz),
        .valid_count(valid_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]              op;
        logic signed [OPW-1:0]   a;
        logic signed [OPW-1:0]   b;
        int                      addr;
        logic signed [2*OPW-1:0] res;
        logic                    dz;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_read(input int addr);
        read_en      = 1'b1;
        read_pointer = AW'(addr);
        tick();
        read_en = 1'b0;
        $display("[TB] read addr=%0d valid=%0d hit=%0d op=%0d a=%0d b=%0d res=%0d dz=%0d",
                 addr, rd_valid, rd_hit, rd_opcode, rd_op_a, rd_op_b, rd_res, rd_dz);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{3'd0, -32'sd7, 32'sd3, 0, 64'sd0, 1'b0};
        vt[1]  = '{3'd1, -32'sd7, 32'sd3, 1, -64'sd7, 1'b0};
        vt[2]  = '{3'd2, -32'sd7, 32'sd3, 2, 64'sd3, 1'b0};
        vt[3]  = '{3'd3, -32'sd7, 32'sd3, 3, -64'sd4, 1'b0};
        vt[4]  = '{3'd4, -32'sd7, 32'sd3, 4, -64'sd10, 1'b0};
        vt[5]  = '{3'd5, -32'sd7, 32'sd3, 5, -64'sd21, 1'b0};
        vt[6]  = '{3'd6, -32'sd7, 32'sd3, 6, -64'sd2, 1'b0};
        vt[7]  = '{3'd7, -32'sd7, 32'sd3, 7, -64'sd1, 1'b0};
        vt[8]  = '{3'd6, 32'sd15, 32'sd0, 10, 64'sd0, 1'b1};
        vt[9]  = '{3'd7, 32'sd15, 32'sd0, 11, 64'sd0, 1'b1};
        vt[10] = '{3'd6, 32'sh8000_0000, -32'sd1, 12, 64'sh0000_0000_8000_0000, 1'b0};
        vt[11] = '{3'd5, 32'sh8000_0000, 32'sh8000_0000, 13, 64'sh4000_0000_0000_0000, 1'b0};

        // Reset and read every entry
        do_reset();
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_count", 64'(valid_count), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            do_read(i);
            chk($sformatf("reset_hit[%0d]", i), 64'(rd_hit), 64'd0);
            chk($sformatf("reset_res[%0d]", i), 64'(rd_res), 64'd0);
            chk($sformatf("reset_cnt[%0d]", i), 64'(valid_count), 64'd0);
        end

`ifdef INSTR_REG_AUTO_INC_EN
        // Six writes wrap a 4-deep store; write_pointer is driven with junk
        for (int i = 1; i <= 6; i++) begin
            load_en       = 1'b1;
            opcode        = 3'd1;
            operand_a     = OPW'(i);
            operand_b     = '0;
            write_pointer = AW'(7 - i);
            tick();
        end
        load_en = 1'b0;
        tick();
        chk("auto_count", 64'(valid_count), 64'd4);
        begin
            int exp_a[4];
            exp_a = '{5, 6, 3, 4};
            for (int i = 0; i < 4; i++) begin
                do_read(i);
                chk($sformatf("auto_hit[%0d]", i), 64'(rd_hit), 64'd1);
                chk($sformatf("auto_a[%0d]", i), 64'(rd_op_a), 64'(exp_a[i]));
                chk($sformatf("auto_res[%0d]", i), 64'(rd_res), 64'(exp_a[i]));
            end
        end
`else
        // Back-to-back writes from the table
        for (int i = 0; i < 12; i++) begin
            load_en       = 1'b1;
            opcode        = vt[i].op;
            operand_a     = vt[i].a;
            operand_b     = vt[i].b;
            write_pointer = AW'(vt[i].addr);
            tick();
            if (i == 8) chk("count_after_8", 64'(valid_count), 64'd8);
        end
        load_en = 1'b0;
        tick();
        chk("count_after_12", 64'(valid_count), 64'd12);
        for (int i = 0; i < 12; i++) begin
            do_read(vt[i].addr);
            chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'd1);
            chk($sformatf("vec%0d_hit", i), 64'(rd_hit), 64'd1);
            chk($sformatf("vec%0d_op", i), 64'(rd_opcode), 64'(vt[i].op));
            chk($sformatf("vec%0d_a", i), 64'(rd_op_a), 64'(vt[i].a));
            chk($sformatf("vec%0d_b", i), 64'(rd_op_b), 64'(vt[i].b));
            chk($sformatf("vec%0d_res", i), 64'(rd_res), 64'(vt[i].res));
            chk($sformatf("vec%0d_dz", i), 64'(rd_dz), 64'(vt[i].dz));
        end

        // Write-first bypass: read at N sees old, read at N+1 sees new
        load_en = 1'b1; opcode = 3'd3; operand_a = 32'sd100; operand_b = 32'sd23;
        write_pointer = AW'(5);
        read_en = 1'b1; read_pointer = AW'(5);
        tick();
        load_en = 1'b0;
        chk("byp_old_res", 64'(rd_res), 64'(-64'sd21));
        chk("byp_old_op", 64'(rd_opcode), 64'd5);
        read_en = 1'b1; read_pointer = AW'(5);
        tick();
        read_en = 1'b0;
        $display("[TB] bypass read addr=5 hit=%0d op=%0d res=%0d", rd_hit, rd_opcode, rd_res);
        chk("byp_new_hit", 64'(rd_hit), 64'd1);
        chk("byp_new_op", 64'(rd_opcode), 64'd3);
        chk("byp_new_res", 64'(rd_res), 64'd123);
        chk("byp_count", 64'(valid_count), 64'd12);
        tick();
        chk("hold_valid", 64'(rd_valid), 64'd0);
        chk("hold_res", 64'(rd_res), 64'd123);

        // Reset while a write to 9 sits in S1
        load_en = 1'b1; opcode = 3'd1; operand_a = 32'sd55; operand_b = 32'sd0;
        write_pointer = AW'(9);
        tick();
        load_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_rd_hit", 64'(rd_hit), 64'd0);
        chk("rst_rd_res", 64'(rd_res), 64'd0);
        tick();
        chk("rst_mid_count", 64'(valid_count), 64'd0);
        do_read(9);
        chk("rst_mid_hit9", 64'(rd_hit), 64'd0);
        chk("rst_mid_res9", 64'(rd_res), 64'd0);
        do_read(3);
        chk("rst_mid_hit3", 64'(rd_hit), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
